// File: rtl/demux_4ch_tdm.sv
// demux_4ch_tdm: rebuilds four lanes from a framed serial stream.
// Four consecutive words, with the first one marked by in_sync, are
// gathered into a frame. The lanes update together once per completed frame.
// Ports:
//   clk, rst_n       rising-edge clock and asynchronous active-low reset
//   in_valid         in_data holds a word this cycle
//   in_sync          the word is slot 0 of a frame (used only while in_valid=1)
//   in_data          incoming word
//   out_a..out_d     lane registers for slots 0 to 3
//   frame_valid      one-cycle pulse: the lanes were updated at the last edge
//   slot             index of the next slot expected
//   err              one-cycle pulse: a framing error was seen at the last edge
//   frame_count      number of completed frames, wrapping modulo 256
module demux_4ch_tdm #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sync,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic             frame_valid,
    output logic [1:0]       slot,
    output logic             err,
    output logic [7:0]       frame_count
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        HUNT    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         slot_d;
    logic [WIDTH-1:0]   sh0_q, sh1_q, sh2_q;
    logic [WIDTH-1:0]   sh0_d, sh1_d, sh2_d;
    logic [WIDTH-1:0]   out_a_d, out_b_d, out_c_d, out_d_d;
    logic               frame_valid_d, err_d;
    logic [CNT_W-1:0]   frame_count_d;

    // State, shadow and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            slot        <= 2'd0;
            sh0_q       <= '0;
            sh1_q       <= '0;
            sh2_q       <= '0;
            out_a       <= '0;
            out_b       <= '0;
            out_c       <= '0;
            out_d       <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            frame_count <= '0;
        end else begin
            state_q     <= state_d;
            slot        <= slot_d;
            sh0_q       <= sh0_d;
            sh1_q       <= sh1_d;
            sh2_q       <= sh2_d;
            out_a       <= out_a_d;
            out_b       <= out_b_d;
            out_c       <= out_c_d;
            out_d       <= out_d_d;
            frame_valid <= frame_valid_d;
            err         <= err_d;
            frame_count <= frame_count_d;
        end
    end

    // Next-state and next-output logic; idle cycles hold everything
    always_comb begin
        state_d       = state_q;
        slot_d        = slot;
        sh0_d         = sh0_q;
        sh1_d         = sh1_q;
        sh2_d         = sh2_q;
        out_a_d       = out_a;
        out_b_d       = out_b;
        out_c_d       = out_c;
        out_d_d       = out_d;
        frame_valid_d = 1'b0;
        err_d         = 1'b0;
        frame_count_d = frame_count;

        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    // Words without sync are dropped silently until aligned
                    if (in_sync) begin
                        sh0_d   = in_data;
                        slot_d  = 2'd1;
                        state_d = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (in_sync) begin
                        // A sync in the middle of a frame restarts it
                        err_d  = (slot != 2'd0);
                        sh0_d  = in_data;
                        slot_d = 2'd1;
                    end else begin
                        unique case (slot)
                            2'd0: begin
                                // A frame start with no sync means alignment is lost
                                err_d   = 1'b1;
                                state_d = HUNT;
                            end
                            2'd1: begin
                                sh1_d  = in_data;
                                slot_d = 2'd2;
                            end
                            2'd2: begin
                                sh2_d  = in_data;
                                slot_d = 2'd3;
                            end
                            default: begin
                                out_a_d       = sh0_q;
                                out_b_d       = sh1_q;
                                out_c_d       = sh2_q;
                                out_d_d       = in_data;
                                frame_valid_d = 1'b1;
                                frame_count_d = frame_count + CNT_W'(1);
                                slot_d        = 2'd0;
                            end
                        endcase
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_4ch_tdm.sv
// Testbench for demux_4ch_tdm. Directed framing scenarios and random traffic
// are checked against a frame-level reference model.
module tb_demux_4ch_tdm;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_sync = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic [WIDTH-1:0] out_a, out_b, out_c, out_d;
    logic             frame_valid;
    logic [1:0]       slot;
    logic             err;
    logic [7:0]       frame_count;

    demux_4ch_tdm #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_sync(in_sync), .in_data(in_data),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
        .frame_valid(frame_valid), .slot(slot), .err(err),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue holds the partial frame while the model is aligned
    bit aligned;
    int frame[$];
    int lanes[4];
    int cnt;
    bit m_fv, m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        aligned = 1'b0;
        frame.delete();
        for (int i = 0; i < 4; i++) lanes[i] = 0;
        cnt   = 0;
        m_fv  = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_word(input bit v, input bit s, input int d);
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (!v) return;
        if (s) begin
            if (aligned && frame.size() != 0) m_err = 1'b1;
            frame.delete();
            frame.push_back(d);
            aligned = 1'b1;
        end else if (aligned) begin
            if (frame.size() == 0) begin
                m_err   = 1'b1;
                aligned = 1'b0;
            end else begin
                frame.push_back(d);
                if (frame.size() == 4) begin
                    for (int i = 0; i < 4; i++) lanes[i] = frame[i];
                    cnt  = (cnt + 1) % 256;
                    m_fv = 1'b1;
                    frame.delete();
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_a"}, 32'(out_a), 32'(lanes[0]));
        chk({tag, ".out_b"}, 32'(out_b), 32'(lanes[1]));
        chk({tag, ".out_c"}, 32'(out_c), 32'(lanes[2]));
        chk({tag, ".out_d"}, 32'(out_d), 32'(lanes[3]));
        chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(m_fv));
        chk({tag, ".err"}, 32'(err), 32'(m_err));
        chk({tag, ".slot"}, 32'(slot), 32'(frame.size()));
        chk({tag, ".frame_count"}, 32'(frame_count), 32'(cnt));
    endtask

    // One clock: drive on the falling edge, check just after the rising edge
    task automatic step(input string tag, input bit v, input bit s, input logic [WIDTH-1:0] d);
        @(negedge clk);
        in_valid = v;
        in_sync  = s;
        in_data  = d;
        @(posedge clk);
        model_word(v, s, int'(d));
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++)
            step(tag, 1'b0, 1'($urandom_range(1)), WIDTH'($urandom));
    endtask

    task automatic send_frame(input string tag, input int a, input int b, input int c, input int d);
        step(tag, 1'b1, 1'b1, WIDTH'(a));
        step(tag, 1'b1, 1'b0, WIDTH'(b));
        step(tag, 1'b1, 1'b0, WIDTH'(c));
        step(tag, 1'b1, 1'b0, WIDTH'(d));
    endtask

    initial begin
        model_reset();

        // Reset held for two cycles
        #2;
        check_all("reset_a");
        @(negedge clk);
        check_all("reset_b");
        @(negedge clk);
        rst_n = 1'b1;

        // First frame 1,2,3,4
        send_frame("frame1", 1, 2, 3, 4);
        chk("frame1.lane_d_const", 32'(out_d), 32'd4);
        chk("frame1.count_const", 32'(frame_count), 32'd1);
        chk("frame1.fv_const", 32'(frame_valid), 32'd1);
        idle("frame1_after", 1);
        chk("frame1.fv_drop", 32'(frame_valid), 32'd0);

        // Gapped frame with three idle cycles between words
        step("gap", 1'b1, 1'b1, 4'd5);  idle("gap", 3);
        step("gap", 1'b1, 1'b0, 4'd6);  idle("gap", 3);
        step("gap", 1'b1, 1'b0, 4'd7);  idle("gap", 3);
        step("gap", 1'b1, 1'b0, 4'd8);
        chk("gap.lane_a_const", 32'(out_a), 32'd5);

        // Early sync aborts the partial frame 9,10
        step("early", 1'b1, 1'b1, 4'd9);
        step("early", 1'b1, 1'b0, 4'd10);
        send_frame("early", 11, 12, 13, 14);
        chk("early.count_const", 32'(frame_count), 32'd3);

        // Missing sync after a complete frame
        step("miss", 1'b1, 1'b0, 4'd15);
        chk("miss.err_const", 32'(err), 32'd1);
        step("miss_hunt", 1'b1, 1'b0, 4'd6);
        send_frame("miss", 1, 2, 3, 4);

        // Reset in the middle of a frame
        step("midrst", 1'b1, 1'b1, 4'd7);
        step("midrst", 1'b1, 1'b0, 4'd8);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("midrst_async");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame("after_rst", 1, 2, 3, 4);
        chk("after_rst.count_const", 32'(frame_count), 32'd1);

        // Random traffic with idles, stray syncs and dropped words
        for (int i = 0; i < 600; i++) begin
            bit v, s;
            v = ($urandom_range(3) != 0);
            s = ($urandom_range(4) == 0);
            step("random", v, s, WIDTH'($urandom));
        end

        // 256 back-to-back frames for the counter wrap
        for (int f = 0; f < 256; f++)
            send_frame("wrap", int'($urandom_range(15)), int'($urandom_range(15)),
                       int'($urandom_range(15)), int'($urandom_range(15)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux_4ch_tdm.md
# demux_4ch_tdm

Time-division demultiplexer that receives a framed serial stream of WIDTH-bit words and distributes four consecutive words onto four registered parallel lanes. It is the receive-side counterpart of the 4-to-1 mux path: the mux funnels lanes a, b, c and d onto one bus, and this block rebuilds the four lanes. Lane outputs update atomically, once per complete frame, so downstream logic always sees a coherent set of four values.

## Interface
- WIDTH, 4, bit width of each data word and each lane.
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data holds a word this cycle.
- in_sync  input  1  marks the word as slot 0 (lane a) of a frame; only meaningful when in_valid=1.
- in_data  input  WIDTH  incoming word.
- out_a, out_b, out_c, out_d  output  WIDTH each  lane registers for slots 0, 1, 2 and 3.
- frame_valid  output  1  one-cycle pulse: lanes were updated at the last edge.
- slot  output  2  index of the next slot expected.
- err  output  1  one-cycle pulse: framing error detected at the last edge.
- frame_count  output  8  number of completed frames, wraps from 255 to 0.

## Operation
- States:
  - HUNT: searching for a sync word.
  - CAPTURE: assembling a frame.
- Internal storage: three WIDTH-bit shadow registers, sh0..sh2.
- HUNT:
  - in_valid=1 and in_sync=1: store in_data to sh0, set slot=1, go to CAPTURE.
  - in_valid=1 and in_sync=0: drop the word and stay in HUNT. No err, because the block is not yet aligned.
- CAPTURE, in_valid=1 and in_sync=0:
  - slot=1 or 2: store in_data to sh[slot], then slot=slot+1.
  - slot=3: load out_a=sh0, out_b=sh1, out_c=sh2 and out_d=in_data in the same edge. Pulse frame_valid, set frame_count=frame_count+1 (mod 256), set slot=0, stay in CAPTURE.
  - slot=0: word is missing its sync. Pulse err, drop the word, go to HUNT with slot=0.
- CAPTURE, in_valid=1 and in_sync=1:
  - slot=0: normal frame start. Store in_data to sh0, set slot=1.
  - slot=1, 2 or 3: early sync. Pulse err, discard the partial frame, take the word as the new slot 0 (store to sh0, set slot=1), stay in CAPTURE. Lanes and frame_count are unchanged.
- in_valid=0: the block holds all state, and in_sync is ignored. Idle gaps of any length are allowed between or within frames.
- Lanes change only on frame completion. Partial or aborted frames never reach out_*.
- Shadow registers are not required to clear on abort. They are always overwritten before use.

## Timing
- Reset (async assert, released synchronously to clk by the system):
  - state=HUNT, slot=0.
  - out_a..out_d=0, frame_valid=0, err=0, frame_count=0.
  - Shadows cleared to 0.
- Reset asserted mid-frame: everything returns to reset values immediately. The partial frame is lost, and there is no frame_valid or err pulse.
- Latency: at the rising edge that samples the slot-3 word, out_* and frame_count update and frame_valid goes high. frame_valid is low again after the next edge unless that edge also completes a frame.
- Throughput: one word per cycle. Back-to-back frames yield a frame_valid pulse every 4th cycle.
- err and frame_valid are registered and never both high in the same cycle.
- All outputs are driven directly from flops. There is no combinational path from any input to any output.
- frame_count wrap: 255 + 1 -> 0, with no flag.

## Test plan
- Reset then frame: rst_n low for 2 cycles, then words 1(sync), 2, 3, 4 on consecutive cycles.
  - During reset: all outputs 0.
  - Edge after word 4: out_a..d=1,2,3,4, frame_valid=1 for exactly one cycle, frame_count=1, slot=0.
- Gapped frame: send 5(sync), 6, 7, 8 with in_valid low for 3 cycles between each word.
  - out_* hold 1,2,3,4 until word 8 is accepted, then become 5,6,7,8.
  - slot steps 1, 2, 3, 0.
- Early sync: send 9(sync), 10, then 11(sync), 12, 13, 14.
  - err pulses one cycle at the edge that takes word 11.
  - Lanes then become 11,12,13,14, and frame_count increments only once.
- Missing sync: after a complete frame, send word 15 without sync, then 1(sync), 2, 3, 4.
  - err pulses when word 15 is dropped and state goes to HUNT.
  - The next frame completes normally with lanes 1,2,3,4.
- Reset mid-frame: send 7(sync), 8, then pulse rst_n low.
  - All outputs read 0 asynchronously.
  - A following frame 1,2,3,4 completes with frame_count=1.
- Wrap: stream 256 back-to-back frames.
  - frame_count goes 255 -> 0.
  - frame_valid pulses every 4th cycle and err never asserts.
